// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline definitions: NOP encoding, Controller select codes and fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_REDIR = 2'b01;
    localparam logic [1:0] PC_STALL = 2'b10;

    localparam logic [1:0] INSTR_PASS   = 2'b00;
    localparam logic [1:0] INSTR_SQUASH = 2'b10;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_HOLD  = 2'd2,
        FS_FLUSH = 2'd3
    } fetch_state_e;

    // Encodings 10 and 11 both squash; 01 behaves like pass.
    function automatic logic is_squash(input logic [1:0] sel);
        return sel[1];
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// 33-bit instruction+valid capture register; sel=1 presents the captured word, sel=0 passes through.
module if_skid_buffer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel,
    input  logic [31:0] cap_instr,
    input  logic        cap_valid,
    input  logic [31:0] pass_instr,
    input  logic        pass_valid,
    output logic [31:0] q_instr,
    output logic        q_valid
);

    logic [32:0] skid_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_p1 <= {NOP_INSTR, 1'b0};
        end else if (load) begin
            skid_p1 <= {cap_instr, cap_valid};
        end
    end

    assign q_instr = sel ? skid_p1[32:1] : pass_instr;
    assign q_valid = sel ? skid_p1[0]    : pass_valid;

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: owns the PC, drives the synchronous IM port, produces the IF/ID pair.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      target_pc,
    input  logic [1:0]       instr_sel,
    output logic             im_ceb,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    output logic [31:0]      pc_if,
    output logic [31:0]      pc_id,
    output logic [31:0]      instr_id,
    output logic             instr_valid_id
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      flush_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [1:0] BOOT  = FS_BOOT;
    localparam logic [1:0] RUN   = FS_RUN;
    localparam logic [1:0] HOLD  = FS_HOLD;
    localparam logic [1:0] FLUSH = FS_FLUSH;

    logic [31:0] pc_p0;
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        redirect;
    logic        stall;
    logic        squash;
    logic        blank;
    logic [31:0] pre_instr;
    logic        pre_valid;
    logic [31:0] cap_instr;
    logic        cap_valid;
    logic [31:0] buf_instr;
    logic        buf_valid;
    logic        unused_bits;

    assign unused_bits = &{1'b0, target_pc[1:0], instr_sel[0]};

    assign redirect = (pc_sel == PC_REDIR);
    assign stall    = (pc_sel == PC_STALL);
    assign squash   = is_squash(instr_sel);

    // Next state depends only on the Controller code; the per-state rules collapse to this.
    always_comb begin
        state_nxt = RUN;
        if (redirect) begin
            state_nxt = FLUSH;
        end else if (stall) begin
            state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc_p0 <= RESET_PC;
            pc_id <= 32'h0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc_p0 <= {target_pc[31:2], 2'b00};
            end else if (!stall) begin
                pc_p0 <= pc_p0 + 32'd4;
            end
            if (!stall) begin
                pc_id <= pc_p0;
            end
        end
    end

    // IF/ID output: BOOT and FLUSH blank the wrong-path/absent word, HOLD replays the skid copy.
    always_comb begin
        blank     = (state == BOOT) || (state == FLUSH);
        pre_instr = blank ? NOP_INSTR : im_dout;
        pre_valid = !blank;
        cap_instr = squash ? NOP_INSTR : pre_instr;
        cap_valid = !squash && pre_valid;
    end

    if_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (stall && (state != HOLD)),
        .sel        (state == HOLD),
        .cap_instr  (cap_instr),
        .cap_valid  (cap_valid),
        .pass_instr (pre_instr),
        .pass_valid (pre_valid),
        .q_instr    (buf_instr),
        .q_valid    (buf_valid)
    );

    assign instr_id       = squash ? NOP_INSTR : buf_instr;
    assign instr_valid_id = !squash && buf_valid;

    // IM is enabled whenever reset is released, including HOLD re-reads.
    assign im_ceb  = !rst;
    assign im_addr = pc_p0[IM_AW+1:2];
    assign pc_if   = pc_p0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= 32'h0;
            flush_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (instr_valid_id && !stall) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((state == FLUSH) || squash) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (state == HOLD) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, mid-cycle reset, and randomized run against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] target_pc = 32'h0;
    logic [1:0]  instr_sel = 2'b00;
    logic        im_ceb;
    logic [13:0] im_addr;
    logic [31:0] im_dout;
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        instr_valid_id;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IM_AW(14)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_sel         (pc_sel),
        .target_pc      (target_pc),
        .instr_sel      (instr_sel),
        .im_ceb         (im_ceb),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .pc_if          (pc_if),
        .pc_id          (pc_id),
        .instr_id       (instr_id),
        .instr_valid_id (instr_valid_id)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return (a == 14'd0) ? 32'h0050_0093 : {2'b10, a, 2'b11, a};
    endfunction

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (!im_ceb) im_dout <= mem_word(im_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Behavioural model, phrased as "what happened in the previous cycle".
    logic [31:0] m_pc, m_pc_id, m_held_i;
    logic        m_held_v, m_blank, m_hold;

    task automatic model_reset();
        m_pc = 32'h0; m_pc_id = 32'h0;
        m_held_i = NOP; m_held_v = 1'b0;
        m_blank = 1'b1; m_hold = 1'b0;
    endtask

    task automatic step(input logic [1:0] sel, input logic [31:0] tgt, input logic [1:0] isel);
        logic [31:0] ei;
        logic        ev;
        logic        redir, stl;
        pc_sel = sel; target_pc = tgt; instr_sel = isel;
        #1;
        redir = (sel == 2'b01);
        stl   = (sel == 2'b10);
        if (isel[1])      begin ei = NOP;      ev = 1'b0;     end
        else if (m_hold)  begin ei = m_held_i; ev = m_held_v; end
        else if (m_blank) begin ei = NOP;      ev = 1'b0;     end
        else              begin ei = mem_word(m_pc_id[15:2] + 14'd0); ev = 1'b1; end
        chk("m_pc_if", pc_if, m_pc);
        chk("m_im_addr", {18'h0, im_addr}, {18'h0, m_pc[15:2]});
        chk("m_pc_id", pc_id, m_pc_id);
        chk("m_instr_id", instr_id, ei);
        chk("m_valid", {31'h0, instr_valid_id}, {31'h0, ev});
        chk("m_im_ceb", {31'h0, im_ceb}, 32'h0);
        if (stl && !m_hold) begin m_held_i = ei; m_held_v = ev; end
        if (!stl) m_pc_id = m_pc;
        if (redir)     m_pc = {tgt[31:2], 2'b00};
        else if (!stl) m_pc = m_pc + 32'd4;
        m_blank = redir;
        m_hold  = stl;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic [1:0]  isel;
        logic [31:0] e_pc_id;
        logic [31:0] e_instr;
        logic        e_v;
        logic [13:0] e_addr;
    } vec_t;

    vec_t tbl[20];

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc_if"}, pc_if, 32'h0);
        chk({tag, "_im_addr"}, {18'h0, im_addr}, 32'h0);
        chk({tag, "_pc_id"}, pc_id, 32'h0);
        chk({tag, "_instr_id"}, instr_id, NOP);
        chk({tag, "_valid"}, {31'h0, instr_valid_id}, 32'h0);
        chk({tag, "_im_ceb"}, {31'h0, im_ceb}, 32'h1);
    endtask

    initial begin
        tbl[0]  = '{2'b00, 32'h0,         2'b00, 32'h0,         NOP,               1'b0, 14'h0};
        tbl[1]  = '{2'b00, 32'h0,         2'b00, 32'h0,         mem_word(14'h0),   1'b1, 14'h1};
        tbl[2]  = '{2'b00, 32'h0,         2'b00, 32'h4,         mem_word(14'h1),   1'b1, 14'h2};
        tbl[3]  = '{2'b10, 32'h0,         2'b00, 32'h8,         mem_word(14'h2),   1'b1, 14'h3};
        tbl[4]  = '{2'b10, 32'h0,         2'b00, 32'h8,         mem_word(14'h2),   1'b1, 14'h3};
        tbl[5]  = '{2'b10, 32'h0,         2'b00, 32'h8,         mem_word(14'h2),   1'b1, 14'h3};
        tbl[6]  = '{2'b00, 32'h0,         2'b00, 32'h8,         mem_word(14'h2),   1'b1, 14'h3};
        tbl[7]  = '{2'b01, 32'h103,       2'b00, 32'hC,         mem_word(14'h3),   1'b1, 14'h4};
        tbl[8]  = '{2'b00, 32'h0,         2'b00, 32'h10,        NOP,               1'b0, 14'h40};
        tbl[9]  = '{2'b10, 32'h0,         2'b00, 32'h100,       mem_word(14'h40),  1'b1, 14'h41};
        tbl[10] = '{2'b01, 32'h200,       2'b00, 32'h100,       mem_word(14'h40),  1'b1, 14'h41};
        tbl[11] = '{2'b00, 32'h0,         2'b10, 32'h104,       NOP,               1'b0, 14'h80};
        tbl[12] = '{2'b00, 32'h0,         2'b11, 32'h200,       NOP,               1'b0, 14'h81};
        tbl[13] = '{2'b10, 32'h0,         2'b10, 32'h204,       NOP,               1'b0, 14'h82};
        tbl[14] = '{2'b00, 32'h0,         2'b00, 32'h204,       NOP,               1'b0, 14'h82};
        tbl[15] = '{2'b11, 32'h0,         2'b01, 32'h208,       mem_word(14'h82),  1'b1, 14'h83};
        tbl[16] = '{2'b01, 32'hFFFF_FFFF, 2'b00, 32'h20C,       mem_word(14'h83),  1'b1, 14'h84};
        tbl[17] = '{2'b00, 32'h0,         2'b00, 32'h210,       NOP,               1'b0, 14'h3FFF};
        tbl[18] = '{2'b00, 32'h0,         2'b00, 32'hFFFF_FFFC, mem_word(14'h3FFF), 1'b1, 14'h0};
        tbl[19] = '{2'b00, 32'h0,         2'b00, 32'h0,         mem_word(14'h0),   1'b1, 14'h1};

        // Power-on reset values.
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Sequential fetch up to pc_if=0x24, then assert reset mid-cycle.
        for (int i = 0; i < 9; i++) step(2'b00, 32'h0, 2'b00);
        chk("pre_rst_pc_if", pc_if, 32'h24);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Directed vectors, cycle 0 is the BOOT cycle after release.
        for (int i = 0; i < 20; i++) begin
            pc_sel = tbl[i].sel; target_pc = tbl[i].tgt; instr_sel = tbl[i].isel;
            #1;
            chk($sformatf("vec%0d_pc_id", i), pc_id, tbl[i].e_pc_id);
            chk($sformatf("vec%0d_instr", i), instr_id, tbl[i].e_instr);
            chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid_id}, {31'h0, tbl[i].e_v});
            chk($sformatf("vec%0d_im_addr", i), {18'h0, im_addr}, {18'h0, tbl[i].e_addr});
            step(tbl[i].sel, tbl[i].tgt, tbl[i].isel);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd5);
`endif

        // Randomized Controller traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] s;
            logic [1:0] is;
            r = $urandom_range(0, 9);
            if (r <= 5)      s = 2'b00;
            else if (r == 6) s = 2'b01;
            else if (r <= 8) s = 2'b10;
            else             s = 2'b11;
            is = {($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1))};
            step(s, $urandom, is);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
